// File: rtl/icache_fill_responder_pkg.sv
// Shared types and line geometry for the icache fill responder.
// The request record is sized from the package geometry constants below.
package taiga_types;

  localparam int unsigned FILL_LINE_WORDS = 4;
  localparam int unsigned FILL_SUB_ID_W   = 2;
  localparam int unsigned FILL_IDX_W      = $clog2(FILL_LINE_WORDS);
  localparam int unsigned FILL_CNT_W      = FILL_IDX_W + 1;
  localparam int unsigned FILL_BASE_W     = 30 - FILL_IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } fill_state_t;

  typedef struct packed {
    logic [FILL_BASE_W-1:0]   base;
    logic [FILL_IDX_W-1:0]    start_idx;
    logic [FILL_CNT_W-1:0]    count;
    logic [FILL_SUB_ID_W-1:0] sub_id;
  } fill_req_t;

  // Word count is req_size+1, clamped to one full line.
  function automatic logic [FILL_CNT_W-1:0] fill_count(input logic [4:0] size);
    if (32'(size) >= FILL_LINE_WORDS) return FILL_CNT_W'(FILL_LINE_WORDS);
    return FILL_CNT_W'(32'(size) + 32'd1);
  endfunction

endpackage

// File: rtl/icache_fill_responder_sequencer.sv
// Per-request word bookkeeping: issued/returned/outstanding counters,
// wrapping word index within the line, and last-issue/last-return flags.
module fill_word_sequencer
  import taiga_types::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FILL_IDX_W-1:0] start_idx,
  input  logic [FILL_CNT_W-1:0] count,
  input  logic                  issue,
  input  logic                  ret,
  output logic [FILL_IDX_W-1:0] word_idx,
  output logic                  can_issue,
  output logic                  last_issue,
  output logic                  last_return
);

  localparam logic [FILL_CNT_W-1:0] CNT_ONE = FILL_CNT_W'(1);

  logic [FILL_CNT_W-1:0] issued;
  logic [FILL_CNT_W-1:0] returned;
  logic [FILL_CNT_W-1:0] outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
    end else if (start) begin
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
    end else begin
      if (issue) issued <= issued + CNT_ONE;
      if (ret) returned <= returned + CNT_ONE;
      if (issue && !ret) outstanding <= outstanding + CNT_ONE;
      else if (!issue && ret) outstanding <= outstanding - CNT_ONE;
    end
  end

  // Index arithmetic truncates to the offset width, so it wraps inside the line.
  assign word_idx    = start_idx + issued[FILL_IDX_W-1:0];
  assign can_issue   = 32'(outstanding) < MAX_OUTSTANDING;
  assign last_issue  = (issued == count - CNT_ONE);
  assign last_return = (returned == count - CNT_ONE);

endmodule

// File: rtl/icache_fill_responder.sv
// Memory-side responder for L1 instruction fills: splits requests into word
// reads and returns data in order. Optional: ICACHE_FILL_CRITICAL_WORD_FIRST_EN.
module icache_fill_responder
  import taiga_types::*;
#(
  parameter int unsigned LINE_WORDS      = FILL_LINE_WORDS,
  parameter int unsigned SUB_ID_W        = FILL_SUB_ID_W,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [4:0]          req_size,
  input  logic [SUB_ID_W-1:0] req_sub_id,
  output logic                mem_rd_req,
  output logic [31:0]         mem_rd_addr,
  input  logic                mem_rd_ack,
  input  logic                mem_rd_data_valid,
  input  logic [31:0]         mem_rd_data,
  output logic                rsp_data_valid,
  output logic [31:0]         rsp_data,
  output logic [SUB_ID_W-1:0] rsp_sub_id,
  output logic                busy
);

  if (LINE_WORDS != FILL_LINE_WORDS || SUB_ID_W != FILL_SUB_ID_W) begin : g_geom_check
    $error("icache_fill_responder: LINE_WORDS/SUB_ID_W must match taiga_types geometry");
  end

  fill_state_t           state, state_next;
  fill_req_t             req;
  logic                  accept, issue, ret;
  logic                  can_issue, last_issue, last_return;
  logic [FILL_IDX_W-1:0] word_idx, req_start;
  logic                  unused_addr;

`ifdef ICACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign req_start = req_addr[1+FILL_IDX_W:2];
`else
  assign req_start = '0;
`endif
  assign unused_addr = ^req_addr[1+FILL_IDX_W:0];

  assign accept = (state == IDLE) && req_valid;
  assign issue  = mem_rd_req && mem_rd_ack;
  assign ret    = (state != IDLE) && mem_rd_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        req.base      <= req_addr[31:2+FILL_IDX_W];
        req.start_idx <= req_start;
        req.count     <= fill_count(req_size);
        req.sub_id    <= req_sub_id;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_rd_req = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        mem_rd_req = can_issue;
        if (can_issue && mem_rd_ack && last_issue)
          state_next = (ret && last_return) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (ret && last_return) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  fill_word_sequencer #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept),
    .start_idx  (req.start_idx),
    .count      (req.count),
    .issue      (issue),
    .ret        (ret),
    .word_idx   (word_idx),
    .can_issue  (can_issue),
    .last_issue (last_issue),
    .last_return(last_return)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_valid <= 1'b0;
      rsp_data       <= '0;
    end else begin
      rsp_data_valid <= ret;
      if (ret) rsp_data <= mem_rd_data;
    end
  end

  assign mem_rd_addr = {req.base, word_idx, 2'b00};
  assign rsp_sub_id  = req.sub_id;
  assign busy        = (state != IDLE) || rsp_data_valid;

  // Returns arriving while idle (e.g. for reads issued before a reset) are dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(state == IDLE && mem_rd_data_valid))
        else $warning("icache_fill_responder: memory return while idle dropped");
    end
  end

endmodule
